led_chase_sequencer: RTL and testbench
======================================

Name: led_chase_sequencer

Overview:
- Parametrised successor to the single-dot LED chaser. Sequences a lit position across an addressable LED strip and hands each frame to the downstream cascade serializer through a start/finished handshake.
- Adds the following over the single-dot chaser: selectable motion modes (bounce, wrap-forward, wrap-reverse, hold), programmable step size, pause, graceful stop/resume, and a frame counter.
- Endpoints are displayed exactly once per bounce, with no dead frames.
- Sits between the top-level switch/button logic and generate_cascade.

Parameters:
- NUM_LEDS, 51, strip length; legal range 2..1023.
- BASE_LATCH_CYCLES, 1000000, hold cycles per frame at speed 0.
- SPEED_W, 4, width of speed input.
- STEP_W, 4, width of step input.
- POS_W, $clog2(NUM_LEDS), position width (derived; do not override).
- LATCH_W, $clog2(BASE_LATCH_CYCLES*2**SPEED_W)+1, latch counter width (derived; do not override).

Ports:
- clk_in  input  1  system clock (100 MHz)
- rst_in  input  1  reset; asynchronous, active-high
- start  input  1  level; leaves IDLE when high
- stop  input  1  level; sampled at LATCH exit
- pause  input  1  level; freezes latch counter
- mode  input  2  0=bounce, 1=wrap-forward, 2=wrap-reverse, 3=hold
- speed  input  SPEED_W  latch length multiplier minus one
- step  input  STEP_W  LEDs advanced per frame
- finished_cascade  input  1  one-cycle pulse from serializer when frame is sent
- position  output  POS_W  lit LED index for the current frame
- start_cascade  output  1  one-cycle frame request pulse
- direction  output  1  1=forward, 0=reverse
- busy  output  1  high whenever state != IDLE
- frame_done  output  1  one-cycle pulse at end of each frame's latch
- frame_count  output  16  completed frames, wraps at 65535->0

Behaviour:
- Reset (async, immediate, no clock edge needed): state=IDLE, position=0, direction=1, start_cascade=0, busy=0, frame_done=0, frame_count=0, latch counter=0.
- All outputs are registered. States: IDLE, TRANSMIT, LATCH, UPDATE.
- IDLE: when start=1, go to TRANSMIT next cycle and assert start_cascade with the current position. position/direction are kept from the last run (resume).
- TRANSMIT:
  - start_cascade is high only in the first TRANSMIT cycle.
  - finished_cascade is ignored in that cycle and in all non-TRANSMIT states.
  - On finished_cascade=1 go to LATCH with counter=0.
  - No timeout.
- LATCH:
  - Target L = BASE_LATCH_CYCLES*(1+speed); speed is sampled on LATCH entry.
  - Counter increments each cycle with pause=0 and holds while pause=1.
  - When counter==L-1 and pause=0: pulse frame_done, increment frame_count, clear counter, then go to IDLE if stop=1, else to UPDATE.
  - LATCH therefore lasts L plus pause-cycle count cycles.
- UPDATE (1 cycle): compute next position from mode and step, then go to TRANSMIT with the start_cascade pulse.
  - mode and step are sampled here.
  - Effective step S: 0 is treated as 1; values >NUM_LEDS-1 clamp to NUM_LEDS-1.
- Position update rules by mode:
  - bounce, forward: if pos+S >= NUM_LEDS-1 then pos=NUM_LEDS-1, dir=0; else pos+=S.
  - bounce, reverse: if pos <= S then pos=0, dir=1; else pos-=S.
  - wrap-forward: pos = pos+S, minus NUM_LEDS if the result is >= NUM_LEDS. Sets dir=1.
  - wrap-reverse: pos = pos-S if pos >= S, else pos+NUM_LEDS-S. Sets dir=0.
  - hold: pos and dir unchanged; frames still transmitted.
- Arithmetic is done at POS_W+1 bits, so there is no overflow at NUM_LEDS near a power of two.
- Mode switches take effect at the next UPDATE. Bounce continues in the current dir.
- Simultaneous start and stop in IDLE: starts, then stops after one frame.
- stop during TRANSMIT/LATCH: the current frame completes first.

Test Plan:
- NUM_LEDS=5, BASE=4, mode=0, step=1, speed=0, start held -> positions 0,1,2,3,4,3,2,1,0,1. Each LATCH exactly 4 cycles; direction falls on the frame showing 4 and rises on the frame showing 0.
- mode=1, step=2 -> 0,2,4,1,3,0. mode=2, step=1 -> 0,4,3,2. step=0 behaves as 1. step=7 in bounce -> 0,4,0,4.
- speed=3 -> LATCH 16 cycles. pause high for 5 cycles mid-LATCH -> 21 cycles. frame_done is a single pulse and frame_count increments by 1.
- Serializer model returns finished_cascade 37 cycles after start_cascade. A spurious finished_cascade during LATCH is ignored. start_cascade is exactly 1 cycle wide per frame.
- stop asserted mid-TRANSMIT at position 2 -> frame completes, LATCH completes, IDLE with busy=0. Re-start shows position 2 first.
- rst_in pulsed asynchronously mid-TRANSMIT -> all outputs reach reset values before the next clk_in edge. A later finished_cascade does not leave IDLE.

Source files
------------

// File: rtl/led_chase_sequencer.sv
// led_chase_sequencer
// Moves a lit position along an addressable LED strip and hands each frame to
// the downstream cascade serializer through a start/finished handshake.
// Motion modes: bounce, wrap-forward, wrap-reverse and hold. Step size is
// programmable. The sequencer also supports pause, a graceful stop/resume, and
// a frame counter. Every output is registered. A frame runs IDLE -> TRANSMIT
// -> LATCH -> UPDATE -> TRANSMIT. Each frame is requested with a one-cycle
// start_cascade pulse.

module led_chase_sequencer #(
  parameter int NUM_LEDS          = 51,
  parameter int BASE_LATCH_CYCLES = 1000000,
  parameter int SPEED_W           = 4,
  parameter int STEP_W            = 4,
  parameter int POS_W             = $clog2(NUM_LEDS),
  parameter int LATCH_W           = $clog2(BASE_LATCH_CYCLES * (2 ** SPEED_W)) + 1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic [1:0]         mode,
  input  logic [SPEED_W-1:0] speed,
  input  logic [STEP_W-1:0]  step,
  input  logic               finished_cascade,
  output logic [POS_W-1:0]   position,
  output logic               start_cascade,
  output logic               direction,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        frame_count
);

  // One extra bit of headroom keeps pos+step and pos+NUM_LEDS-step from
  // overflowing when NUM_LEDS sits just below a power of two.
  localparam int AW = POS_W + 1;
  localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_LEDS - 1);
  localparam logic [AW-1:0] LED_COUNT = AW'(NUM_LEDS);

  localparam logic [1:0] MODE_BOUNCE    = 2'd0;
  localparam logic [1:0] MODE_WRAP_FWD  = 2'd1;
  localparam logic [1:0] MODE_WRAP_REV  = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRANSMIT = 2'd1,
    LATCH    = 2'd2,
    UPDATE   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [LATCH_W-1:0] latch_cnt, latch_cnt_next;
  logic [LATCH_W-1:0] latch_last, latch_last_next;
  logic [LATCH_W-1:0] latch_len;

  logic [POS_W-1:0]   position_next;
  logic               direction_next;
  logic               start_cascade_next;
  logic               busy_next;
  logic               frame_done_next;
  logic [15:0]        frame_count_next;

  logic [AW-1:0]      step_eff;
  logic [AW-1:0]      pos_ext;
  logic [AW-1:0]      pos_sum;
  logic [POS_W-1:0]   adv_pos;
  logic               adv_dir;

  // Condition the requested step: zero means one, and anything beyond the last index is clamped to it.
  always_comb begin
    step_eff = AW'(1);
    if (step == '0) begin
      step_eff = AW'(1);
    end else if (int'(step) > NUM_LEDS - 1) begin
      step_eff = LAST_IDX;
    end else begin
      step_eff = AW'(step);
    end
  end

  // Work out where the dot goes next for the current mode, using widened arithmetic so nothing wraps early.
  always_comb begin
    pos_ext = {1'b0, position};
    pos_sum = pos_ext + step_eff;
    adv_pos = position;
    adv_dir = direction;
    case (mode)
      MODE_BOUNCE: begin
        if (direction) begin
          if (pos_sum >= LAST_IDX) begin
            adv_pos = POS_W'(LAST_IDX);
            adv_dir = 1'b0;
          end else begin
            adv_pos = POS_W'(pos_sum);
          end
        end else begin
          if (pos_ext <= step_eff) begin
            adv_pos = '0;
            adv_dir = 1'b1;
          end else begin
            adv_pos = POS_W'(pos_ext - step_eff);
          end
        end
      end
      MODE_WRAP_FWD: begin
        if (pos_sum >= LED_COUNT) begin
          adv_pos = POS_W'(pos_sum - LED_COUNT);
        end else begin
          adv_pos = POS_W'(pos_sum);
        end
        adv_dir = 1'b1;
      end
      MODE_WRAP_REV: begin
        if (pos_ext >= step_eff) begin
          adv_pos = POS_W'(pos_ext - step_eff);
        end else begin
          adv_pos = POS_W'(pos_ext + LED_COUNT - step_eff);
        end
        adv_dir = 1'b0;
      end
      default: begin
        adv_pos = position;
        adv_dir = direction;
      end
    endcase
  end

  // Frame hold length scales linearly with speed; it is captured once as the latch phase begins.
  always_comb begin
    latch_len = LATCH_W'(BASE_LATCH_CYCLES) * (LATCH_W'(speed) + LATCH_W'(1));
  end

  // Next-state and next-output decode for the frame sequencer.
  always_comb begin
    state_next         = state;
    latch_cnt_next     = latch_cnt;
    latch_last_next    = latch_last;
    position_next      = position;
    direction_next     = direction;
    start_cascade_next = 1'b0;
    frame_done_next    = 1'b0;
    frame_count_next   = frame_count;

    case (state)
      IDLE: begin
        if (start) begin
          state_next         = TRANSMIT;
          start_cascade_next = 1'b1;
        end
      end
      TRANSMIT: begin
        // start_cascade is only high in the first TRANSMIT cycle, so it masks a finish arriving too early.
        if (finished_cascade && !start_cascade) begin
          state_next      = LATCH;
          latch_cnt_next  = '0;
          latch_last_next = latch_len - LATCH_W'(1);
        end
      end
      LATCH: begin
        if (!pause) begin
          if (latch_cnt == latch_last) begin
            frame_done_next  = 1'b1;
            frame_count_next = frame_count + 16'd1;
            latch_cnt_next   = '0;
            state_next       = stop ? IDLE : UPDATE;
          end else begin
            latch_cnt_next = latch_cnt + LATCH_W'(1);
          end
        end
      end
      UPDATE: begin
        position_next      = adv_pos;
        direction_next     = adv_dir;
        state_next         = TRANSMIT;
        start_cascade_next = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered datapath and outputs; direction resets to forward so the first run climbs from LED 0.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      latch_cnt     <= '0;
      latch_last    <= '0;
      position      <= '0;
      direction     <= 1'b1;
      start_cascade <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_count   <= '0;
    end else begin
      latch_cnt     <= latch_cnt_next;
      latch_last    <= latch_last_next;
      position      <= position_next;
      direction     <= direction_next;
      start_cascade <= start_cascade_next;
      busy          <= busy_next;
      frame_done    <= frame_done_next;
      frame_count   <= frame_count_next;
    end
  end

endmodule

// File: tb/tb_led_chase_sequencer.sv
// tb_led_chase_sequencer
// Scoreboard bench for led_chase_sequencer on a 5-LED strip with a 4-cycle base latch.
// A serializer model answers each start_cascade 37 cycles later. Expected
// (position, direction) pairs and latch lengths are queued as each run is
// launched. A monitor pops them as frames and frame_done pulses appear.

module tb_led_chase_sequencer;

  localparam int N       = 5;
  localparam int BASE    = 4;
  localparam int SPEED_W = 4;
  localparam int STEP_W  = 4;
  localparam int POS_W   = $clog2(N);

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b1;
  logic               start  = 1'b0;
  logic               stop   = 1'b0;
  logic               pause  = 1'b0;
  logic [1:0]         mode   = 2'd0;
  logic [SPEED_W-1:0] speed  = '0;
  logic [STEP_W-1:0]  step   = 4'd1;
  logic               ser_fin      = 1'b0;
  logic               spurious_fin = 1'b0;
  logic               finished_cascade;

  logic [POS_W-1:0]   position;
  logic               start_cascade;
  logic               direction;
  logic               busy;
  logic               frame_done;
  logic [15:0]        frame_count;

  int n_cmp  = 0;
  int n_fail = 0;

  int exp_q[$];
  int lat_q[$];
  int model_pos    = 0;
  int model_dir    = 1;
  int model_frames = 0;

  logic latch_armed  = 1'b0;
  int   latch_cycles = 0;
  logic prev_sc      = 1'b0;
  logic prev_fd      = 1'b0;
  int   exp_entry;
  int   exp_latch;

  assign finished_cascade = ser_fin | spurious_fin;

  led_chase_sequencer #(
    .NUM_LEDS(N),
    .BASE_LATCH_CYCLES(BASE),
    .SPEED_W(SPEED_W),
    .STEP_W(STEP_W)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .start(start),
    .stop(stop),
    .pause(pause),
    .mode(mode),
    .speed(speed),
    .step(step),
    .finished_cascade(finished_cascade),
    .position(position),
    .start_cascade(start_cascade),
    .direction(direction),
    .busy(busy),
    .frame_done(frame_done),
    .frame_count(frame_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference motion model in plain integer arithmetic.
  function automatic void advanceModel(input int m, input int st);
    int s;
    s = (st == 0) ? 1 : ((st > N - 1) ? N - 1 : st);
    case (m)
      0: begin
        if (model_dir == 1) begin
          if (model_pos + s >= N - 1) begin
            model_pos = N - 1;
            model_dir = 0;
          end else begin
            model_pos = model_pos + s;
          end
        end else begin
          if (model_pos <= s) begin
            model_pos = 0;
            model_dir = 1;
          end else begin
            model_pos = model_pos - s;
          end
        end
      end
      1: begin
        model_pos = (model_pos + s) % N;
        model_dir = 1;
      end
      2: begin
        model_pos = (model_pos - s + N) % N;
        model_dir = 0;
      end
      default: begin
      end
    endcase
  endfunction

  // Queue the expected frames of a run, then pulse start for one cycle.
  task automatic applyStimulus(input int m, input int st, input int sp, input int nframes);
    for (int i = 0; i < nframes; i++) begin
      exp_q.push_back(model_pos * 2 + model_dir);
      lat_q.push_back(BASE * (sp + 1));
      if (i < nframes - 1) advanceModel(m, st);
    end
    @(negedge clk_in);
    mode  = 2'(m);
    step  = 4'(st);
    speed = 4'(sp);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  // Wait for the last queued frame to be requested, then stop the run gracefully.
  task automatic finishSegment(input string tag);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 3000) begin
      @(negedge clk_in);
      budget++;
    end
    checkOutput({tag, "_frames_left"}, exp_q.size(), 0);
    stop   = 1'b1;
    budget = 0;
    while (busy !== 1'b0 && budget < 500) begin
      @(negedge clk_in);
      budget++;
    end
    stop = 1'b0;
    @(negedge clk_in);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_latch_left"}, lat_q.size(), 0);
    checkOutput({tag, "_pos"}, 32'(position), model_pos);
  endtask

  // Asynchronous reset between clock edges; outputs must settle before the next rising edge.
  task automatic resetDut(input string tag);
    @(negedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    checkOutput({tag, "_rst_pos"}, 32'(position), 0);
    checkOutput({tag, "_rst_dir"}, 32'(direction), 1);
    checkOutput({tag, "_rst_sc"}, 32'(start_cascade), 0);
    checkOutput({tag, "_rst_busy"}, 32'(busy), 0);
    checkOutput({tag, "_rst_fd"}, 32'(frame_done), 0);
    checkOutput({tag, "_rst_count"}, 32'(frame_count), 0);
    exp_q.delete();
    lat_q.delete();
    model_pos    = 0;
    model_dir    = 1;
    model_frames = 0;
    latch_armed  = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  // Serializer model: finished_cascade returns 37 cycles after each frame request.
  initial begin
    forever begin
      @(negedge clk_in);
      if (start_cascade === 1'b1 && rst_in === 1'b0) begin
        repeat (36) @(negedge clk_in);
        ser_fin = 1'b1;
        @(negedge clk_in);
        ser_fin = 1'b0;
      end
    end
  end

  // Monitor: score frame requests, latch lengths, pulse widths and the frame counter.
  initial begin
    forever begin
      @(negedge clk_in);
      if (rst_in !== 1'b0) begin
        prev_sc     = 1'b0;
        prev_fd     = 1'b0;
        latch_armed = 1'b0;
      end else begin
        if (start_cascade === 1'b1) begin
          checkOutput("sc_width", 32'(prev_sc), 0);
          exp_entry = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
          checkOutput("frame_pos_dir", 32'({position, direction}), exp_entry);
        end
        if (ser_fin === 1'b1) begin
          latch_armed  = 1'b1;
          latch_cycles = -1;
        end else if (latch_armed) begin
          latch_cycles++;
        end
        if (frame_done === 1'b1) begin
          checkOutput("fd_width", 32'(prev_fd), 0);
          exp_latch = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
          checkOutput("latch_len", latch_armed ? latch_cycles : -1, exp_latch);
          latch_armed = 1'b0;
          model_frames++;
          checkOutput("frame_count", 32'(frame_count), model_frames);
        end
        prev_sc = start_cascade;
        prev_fd = frame_done;
      end
    end
  end

  // Hard time limit so the bench always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence of runs.
  initial begin
    int budget;

    resetDut("boot");

    // Bounce, step 1: 0 1 2 3 4 3 2 1 0 1
    applyStimulus(0, 1, 0, 10);
    finishSegment("bounce");

    resetDut("wf");
    applyStimulus(1, 2, 0, 6);
    finishSegment("wrapfwd");

    resetDut("wr");
    applyStimulus(2, 1, 0, 4);
    finishSegment("wraprev");

    resetDut("s0");
    applyStimulus(0, 0, 0, 3);
    finishSegment("step0");

    resetDut("s7");
    applyStimulus(0, 7, 0, 4);
    finishSegment("step7");

    // Speed 3 with a 5-cycle pause in the first frame and spurious finishes
    resetDut("spd");
    applyStimulus(0, 1, 3, 2);
    lat_q[0] = 21;
    spurious_fin = 1'b1;
    @(negedge clk_in);
    spurious_fin = 1'b0;
    budget = 0;
    while (ser_fin !== 1'b1 && budget < 200) begin
      @(negedge clk_in);
      budget++;
    end
    checkOutput("ser_fin_seen", 32'(ser_fin), 1);
    repeat (3) @(negedge clk_in);
    pause = 1'b1;
    repeat (2) @(negedge clk_in);
    spurious_fin = 1'b1;
    @(negedge clk_in);
    spurious_fin = 1'b0;
    repeat (2) @(negedge clk_in);
    pause = 1'b0;
    finishSegment("speed");

    // Hold mode resumes from the retained position
    applyStimulus(3, 1, 0, 3);
    finishSegment("hold");

    // Stop during the frame showing 2, then resume at 2
    resetDut("stp");
    applyStimulus(0, 1, 0, 3);
    finishSegment("stopmid");
    applyStimulus(0, 1, 0, 2);
    finishSegment("resume");

    // Asynchronous reset in the middle of a transmit
    applyStimulus(0, 1, 0, 1);
    repeat (5) @(negedge clk_in);
    resetDut("midtx");
    repeat (60) @(negedge clk_in);
    checkOutput("post_rst_busy", 32'(busy), 0);
    checkOutput("post_rst_pos", 32'(position), 0);
    checkOutput("post_rst_count", 32'(frame_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
